// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  localparam int PWM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } pwm_state_e;

endpackage

// File: rtl/pwm_in_conditioner.sv
// Synchronizes the raw PWM line and produces one-cycle rise/fall strobes.
// PWM_CAPTURE_FILTER_EN adds a 3-sample majority filter (+1 clock latency).
module pwm_in_conditioner
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic [PWM_SYNC_STAGES-1:0] sync_q;
  logic                       sync_line;
  logic                       line;
  logic                       line_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[PWM_SYNC_STAGES-2:0], pwm_i};
    end
  end

  assign sync_line = sync_q[PWM_SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], sync_line};
    end
  end

  // A level must be seen in two of the last three samples to pass.
  assign line = (sync_line & hist_q[0]) | (sync_line & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign line = sync_line;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= 1'b0;
    end else begin
      line_q <= line;
    end
  end

  assign rise_o = line & ~line_q;
  assign fall_o = ~line & line_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period (length-1) and high time; flags a stuck line.
// PWM_CAPTURE_FILTER_EN enables the input majority filter in the conditioner.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pwm_in,
  output logic [COUNTER_WIDTH-1:0] period_out,
  output logic [COUNTER_WIDTH-1:0] duty_out,
  output logic                     meas_valid,
  output logic                     stuck_high,
  output logic                     stuck_low
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W:0] CNT_MAX = {1'b1, {W{1'b0}}};
  localparam logic [W:0] CNT_ONE = {{W{1'b0}}, 1'b1};

  typedef logic [W-1:0] cnt_w_t;

  logic       rise;
  logic       fall;

  pwm_state_e state_q, state_d;
  logic [W:0] cnt_q, cnt_d;
  cnt_w_t     hcnt_q, hcnt_d;
  cnt_w_t     period_q, period_d;
  cnt_w_t     duty_q, duty_d;
  logic       valid_q, valid_d;
  logic       sth_q, sth_d;
  logic       stl_q, stl_d;

  pwm_in_conditioner u_cond (
    .clk    (clk),
    .reset  (reset),
    .pwm_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      sth_q    <= 1'b0;
      stl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      sth_q    <= sth_d;
      stl_q    <= stl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    sth_d    = sth_q;
    stl_d    = stl_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        // An edge always takes priority over the timeout.
        if (fall) begin
          hcnt_d  = cnt_q[W-1:0];
          state_d = LOW;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STUCK;
          sth_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          period_d = cnt_w_t'(cnt_q - 1'b1);
          duty_d   = hcnt_q;
          valid_d  = 1'b1;
          state_d  = HIGH;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STUCK;
          stl_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STUCK: begin
        // The cycle that ends a stuck period is partial, so it is not reported.
        if (rise) begin
          sth_d   = 1'b0;
          stl_d   = 1'b0;
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period_out = period_q;
  assign duty_out   = duty_q;
  assign meas_valid = valid_q;
  assign stuck_high = sth_q;
  assign stuck_low  = stl_q;

endmodule
